// File: rtl/aes_engine_scheduler.sv
// Round-robin scheduler sharing one encrypt engine between NUM_REQ requesters.
// Caches the last loaded key to skip reloads and aborts jobs that exceed TIMEOUT cycles.
module aes_engine_scheduler #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 32,
  localparam int ID_W  = $clog2(NUM_REQ),
  localparam int TMR_W = $clog2(TIMEOUT + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*128-1:0] req_state,
  input  logic [NUM_REQ*128-1:0] req_key,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [127:0]           rsp_data,
  output logic                   rsp_err,
  output logic                   busy,
  output logic                   eng_start,
  output logic                   eng_set_key,
  output logic                   eng_halt,
  output logic [127:0]           eng_state,
  output logic [127:0]           eng_key,
  input  logic [127:0]           eng_out,
  input  logic                   eng_out_valid
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_ABORT = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [127:0]       pt_q, pt_d;
  logic [127:0]       key_q, key_d;
  logic [127:0]       cache_key_q, cache_key_d;
  logic               cache_vld_q, cache_vld_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [127:0]       rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;

  logic               grant_found_s;
  logic [ID_W-1:0]    grant_idx_s;
  logic [NUM_REQ-1:0] req_ready_s;
  logic               key_hit_s;

  function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] ptr, input int off);
    int sum;
    sum = int'(ptr) + off;
    return ID_W'(sum % NUM_REQ);
  endfunction

  // Circular search for the first valid requester at or after rr_ptr.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found_s && req_valid[rr_index(rr_ptr_q, i)]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = rr_index(rr_ptr_q, i);
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  assign key_hit_s = cache_vld_q && (cache_key_q == key_q);

  // Next-state and datapath update logic for the job sequencer.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    pt_d        = pt_q;
    key_d       = key_q;
    cache_key_d = cache_key_q;
    cache_vld_d = cache_vld_q;
    timer_d     = timer_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    req_ready_s = '0;
    case (state_q)
      S_IDLE: begin
        if (grant_found_s) begin
          req_ready_s[grant_idx_s] = 1'b1;
          id_d     = grant_idx_s;
          pt_d     = req_state[int'(grant_idx_s) * 128 +: 128];
          key_d    = req_key[int'(grant_idx_s) * 128 +: 128];
          rr_ptr_d = rr_index(grant_idx_s, 1);
          state_d  = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        cache_key_d = key_q;
        cache_vld_d = 1'b1;
        timer_d     = '0;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        // A result arriving on the timeout cycle still counts as success.
        if (eng_out_valid) begin
          rsp_data_d = eng_out;
          rsp_err_d  = 1'b0;
          state_d    = S_RESP;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          state_d = S_ABORT;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_ABORT: begin
        cache_vld_d = 1'b0;
        rsp_data_d  = 128'd0;
        rsp_err_d   = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      pt_q        <= 128'd0;
      key_q       <= 128'd0;
      cache_key_q <= 128'd0;
      cache_vld_q <= 1'b0;
      timer_q     <= '0;
      rsp_data_q  <= 128'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      pt_q        <= pt_d;
      key_q       <= key_d;
      cache_key_q <= cache_key_d;
      cache_vld_q <= cache_vld_d;
      timer_q     <= timer_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Accept pulse is suppressed while reset is asserted so no job is taken then.
  assign req_ready   = req_ready_s & {NUM_REQ{rst_n}};
  assign eng_start   = (state_q == S_ISSUE);
  assign eng_set_key = (state_q == S_ISSUE) && !key_hit_s;
  assign eng_halt    = (state_q == S_ABORT);
  assign rsp_valid   = (state_q == S_RESP);
  assign busy        = (state_q != S_IDLE);
  assign rsp_id      = id_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign eng_state   = pt_q;
  assign eng_key     = key_q;

endmodule

// File: tb/tb_aes_engine_scheduler.sv
// Self-checking bench: behavioural engine stand-in plus a job-level reference model
// (round-robin pointer, key cache, cipher function) driving directed and random jobs.
module tb_aes_engine_scheduler;
  localparam int TO = 12;

  localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [255:0] req_state;
  logic [255:0] req_key;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [127:0] rsp_data;
  logic         rsp_err;
  logic         busy;
  logic         eng_start;
  logic         eng_set_key;
  logic         eng_halt;
  logic [127:0] eng_state;
  logic [127:0] eng_key;
  logic [127:0] eng_out;
  logic         eng_out_valid;

  int n_cmp  = 0;
  int n_fail = 0;

  // engine stand-in state
  logic [127:0] eng_key_store = 128'd0;
  logic [127:0] eng_pt_store  = 128'd0;
  logic [127:0] eng_out_m     = 128'd0;
  logic         eng_vld_m     = 1'b0;
  bit           eng_pending   = 1'b0;
  int           eng_cnt       = 0;
  int           eng_lat       = 3;
  bit           eng_hang      = 1'b0;
  logic         inj_vld       = 1'b0;
  logic [127:0] inj_data      = 128'd0;

  // reference model state
  int           m_ptr = 0;
  bit           m_cv  = 1'b0;
  logic [127:0] m_ck  = 128'd0;

  aes_engine_scheduler #(.NUM_REQ(2), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_state(req_state), .req_key(req_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .eng_start(eng_start), .eng_set_key(eng_set_key), .eng_halt(eng_halt),
    .eng_state(eng_state), .eng_key(eng_key),
    .eng_out(eng_out), .eng_out_valid(eng_out_valid)
  );

  always #5 clk = ~clk;

  assign eng_out_valid = eng_vld_m | inj_vld;
  assign eng_out       = inj_vld ? inj_data : eng_out_m;

  // Stand-in cipher: the known test vector, otherwise a keyed mixing of the block.
  function automatic logic [127:0] cipher(input logic [127:0] pt, input logic [127:0] k);
    if (k == K0 && pt == P0) return C0;
    return pt ^ {k[63:0], k[127:64]} ^ 128'h5a5a_c3c3_0ff0_1234_a5a5_3c3c_f00f_4321;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [127:0] pt, input logic [127:0] k);
    req_state[128*i +: 128] = pt;
    req_key[128*i +: 128]   = k;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req_ready"}, 128'(req_ready), 128'd0);
    chk({tag, "_rsp_valid"}, 128'(rsp_valid), 128'd0);
    chk({tag, "_rsp_id"}, 128'(rsp_id), 128'd0);
    chk({tag, "_rsp_data"}, rsp_data, 128'd0);
    chk({tag, "_rsp_err"}, 128'(rsp_err), 128'd0);
    chk({tag, "_busy"}, 128'(busy), 128'd0);
    chk({tag, "_eng_ctl"}, 128'({eng_start, eng_set_key, eng_halt}), 128'd0);
    chk({tag, "_eng_state"}, eng_state, 128'd0);
    chk({tag, "_eng_key"}, eng_key, 128'd0);
  endtask

  // Engine stand-in: loads key on start+set_key, answers after eng_lat cycles unless hung.
  always begin
    bit rst_seen;
    @(posedge clk);
    rst_seen = rst_n;
    #1;
    eng_vld_m = 1'b0;
    if (!rst_seen) begin
      eng_pending   = 1'b0;
      eng_key_store = 128'd0;
    end else begin
      if (eng_pending) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          eng_vld_m   = 1'b1;
          eng_out_m   = cipher(eng_pt_store, eng_key_store);
          eng_pending = 1'b0;
        end
      end
      if (eng_halt) eng_pending = 1'b0;
      if (eng_start) begin
        if (eng_set_key) eng_key_store = eng_key;
        eng_pt_store = eng_state;
        if (!eng_hang) begin
          eng_pending = 1'b1;
          eng_cnt     = eng_lat;
        end
      end
    end
  end

  // One complete job from grant to response handshake; starts and ends at +1 of an IDLE cycle.
  task automatic do_job(input logic [1:0] vm, input int lat, input bit hang, input int bp);
    int g;
    int idx;
    int cnt;
    int halt_cnt;
    int exp_lat;
    int exp_halt;
    logic [1:0]   exp_rdy;
    logic [127:0] pt;
    logic [127:0] k;
    logic [127:0] exp_d;
    bit           exp_sk;
    g = -1;
    for (int j = 0; j < 2; j++) begin
      idx = (m_ptr + j) % 2;
      if (g < 0 && vm[idx]) g = idx;
    end
    eng_lat   = lat;
    eng_hang  = hang;
    req_valid = vm;
    #2;
    exp_rdy = 2'b00;
    exp_rdy[g] = 1'b1;
    chk("grant_busy", 128'(busy), 128'd0);
    chk("grant_ready", 128'(req_ready), 128'(exp_rdy));
    pt     = req_state[128*g +: 128];
    k      = req_key[128*g +: 128];
    m_ptr  = (g + 1) % 2;
    exp_sk = !(m_cv && m_ck == k);
    m_cv   = 1'b1;
    m_ck   = k;
    exp_d  = hang ? 128'd0 : cipher(pt, k);
    adv();
    #2;
    chk("issue_start", 128'(eng_start), 128'd1);
    chk("issue_set_key", 128'(eng_set_key), 128'(exp_sk));
    chk("issue_state", eng_state, pt);
    chk("issue_key", eng_key, k);
    chk("issue_ready", 128'(req_ready), 128'd0);
    cnt = 0;
    halt_cnt = 0;
    while (!rsp_valid && cnt < TO + 20) begin
      adv();
      #2;
      cnt++;
      if (eng_halt) halt_cnt = cnt;
      chk("wait_ready", 128'(req_ready), 128'd0);
      chk("wait_start", 128'(eng_start), 128'd0);
    end
    if (hang) begin
      m_cv     = 1'b0;
      exp_lat  = TO + 2;
      exp_halt = TO + 1;
    end else begin
      exp_lat  = lat + 1;
      exp_halt = 0;
    end
    chk("rsp_valid", 128'(rsp_valid), 128'd1);
    chk("rsp_latency", 128'(cnt), 128'(exp_lat));
    chk("halt_cycle", 128'(halt_cnt), 128'(exp_halt));
    chk("rsp_id", 128'(rsp_id), 128'(g));
    chk("rsp_data", rsp_data, exp_d);
    chk("rsp_err", 128'(rsp_err), 128'(hang));
    for (int i = 0; i < bp; i++) begin
      adv();
      #2;
      chk("bp_valid", 128'(rsp_valid), 128'd1);
      chk("bp_id", 128'(rsp_id), 128'(g));
      chk("bp_data", rsp_data, exp_d);
      chk("bp_err", 128'(rsp_err), 128'(hang));
      chk("bp_ready", 128'(req_ready), 128'd0);
    end
    rsp_ready = 1'b1;
    adv();
    rsp_ready = 1'b0;
    req_valid = 2'b00;
  endtask

  initial begin
    logic [127:0] ka;
    logic [127:0] kb;
    logic [127:0] kc;
    rst_n     = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 1'b0;
    req_state = {rnd128(), rnd128()};
    req_key   = {rnd128(), rnd128()};
    ka = rnd128();
    kb = rnd128();

    // reset with requests pending: nothing granted, all outputs zero
    adv();
    #2;
    chk_zero("reset");
    req_valid = 2'b00;
    rst_n     = 1'b1;
    adv();

    // known vector, then key reuse, then a fresh key
    set_req(0, P0, K0);
    do_job(2'b01, 5, 1'b0, 0);
    set_req(0, rnd128(), K0);
    do_job(2'b01, 2, 1'b0, 0);
    set_req(0, rnd128(), ka);
    do_job(2'b01, 1, 1'b0, 0);

    // fairness with both held, then only requester 1
    for (int i = 0; i < 4; i++) begin
      set_req(0, rnd128(), ka);
      set_req(1, rnd128(), kb);
      do_job(2'b11, 2, 1'b0, 0);
    end
    for (int i = 0; i < 3; i++) begin
      set_req(1, rnd128(), kb);
      do_job(2'b10, 3, 1'b0, 0);
    end

    // timeout, then the same key must be reloaded
    set_req(0, rnd128(), ka);
    do_job(2'b01, 1, 1'b1, 0);
    set_req(0, rnd128(), ka);
    do_job(2'b01, 4, 1'b0, 0);

    // result on the last allowed cycle, then backpressure
    set_req(1, rnd128(), ka);
    do_job(2'b10, TO, 1'b0, 0);
    set_req(0, rnd128(), kb);
    do_job(2'b01, 3, 1'b0, 10);

    // random traffic over a small key pool
    for (int i = 0; i < 14; i++) begin
      set_req(0, rnd128(), ($urandom_range(0, 1) == 0) ? ka : kb);
      set_req(1, rnd128(), ($urandom_range(0, 1) == 0) ? ka : kb);
      do_job(2'($urandom_range(1, 3)), $urandom_range(1, TO),
             ($urandom_range(0, 5) == 0), $urandom_range(0, 3));
    end

    // reset during WAIT; a late engine strobe must be ignored
    kc = rnd128();
    set_req(0, rnd128(), kc);
    set_req(1, rnd128(), kc);
    eng_hang  = 1'b1;
    req_valid = 2'b11;
    adv();
    req_valid = 2'b00;
    adv();
    adv();
    adv();
    #2;
    chk("midrst_busy", 128'(busy), 128'd1);
    rst_n = 1'b0;
    adv();
    #2;
    chk_zero("midrst");
    rst_n    = 1'b1;
    inj_data = rnd128();
    inj_vld  = 1'b1;
    adv();
    inj_vld = 1'b0;
    #2;
    chk("late_rsp_valid", 128'(rsp_valid), 128'd0);
    chk("late_busy", 128'(busy), 128'd0);
    adv();
    #2;
    chk("late_rsp_valid2", 128'(rsp_valid), 128'd0);
    adv();
    m_ptr = 0;
    m_cv  = 1'b0;
    set_req(0, rnd128(), kc);
    set_req(1, rnd128(), kc);
    do_job(2'b11, 3, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
